// File: rtl/viterbi_frame_ctrl.sv
// Frame controller in front of a Viterbi decoder: feeds one frame of coded pairs,
// appends flush pairs, forwards decoded bits and aborts on a stalled decoder.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN = 648,
  parameter int FLUSH_LEN = 20,
  parameter int OUT_LEN   = 628,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic        start,
  input  logic        s_valid,
  input  logic [1:0]  s_data,
  output logic        s_ready,
  output logic        d_in_valid,
  output logic [1:0]  d_in,
  input  logic        d_out_valid,
  input  logic        d_out,
  output logic        m_valid,
  output logic        m_data,
  output logic        m_last,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic [10:0] bit_cnt
);

  typedef enum logic [2:0] {IDLE, FEED, FLUSH, DRAIN, DONE} state_t;

  localparam logic [10:0] FRAME_LAST = 11'(FRAME_LEN - 1);
  localparam logic [10:0] FLUSH_LAST = 11'(FLUSH_LEN - 1);
  localparam logic [10:0] OUT_TOTAL  = 11'(OUT_LEN);
  localparam logic [10:0] OUT_LAST   = 11'(OUT_LEN - 1);
  localparam logic [10:0] WD_LAST    = 11'(TIMEOUT - 1);

  state_t      state;
  logic [10:0] in_cnt;
  logic [10:0] flush_cnt;
  logic [10:0] wd_cnt;

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and is not in the sensitivity list.
    if (!RSTn) begin
      state       <= IDLE;
      in_cnt      <= '0;
      flush_cnt   <= '0;
      wd_cnt      <= '0;
      s_ready     <= 1'b0;
      d_in_valid  <= 1'b0;
      d_in        <= 2'b00;
      m_valid     <= 1'b0;
      m_data      <= 1'b0;
      m_last      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      bit_cnt     <= '0;
    end else begin
      // NOTE: pulse outputs get a default here so any cycle that does not re-assert them drops them.
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;

      unique case (state)
        IDLE: begin
          s_ready    <= 1'b0;
          d_in_valid <= 1'b0;
          if (start) begin
            state     <= FEED;
            busy      <= 1'b1;
            s_ready   <= 1'b1;
            in_cnt    <= '0;
            flush_cnt <= '0;
            wd_cnt    <= '0;
            bit_cnt   <= '0;
          end
        end

        FEED: begin
          d_in_valid <= 1'b0;
          if (s_valid && s_ready) begin
            d_in       <= s_data;
            d_in_valid <= 1'b1;
            in_cnt     <= in_cnt + 11'd1;
            if (in_cnt == FRAME_LAST) begin
              state   <= FLUSH;
              s_ready <= 1'b0;
            end
          end
        end

        FLUSH: begin
          d_in       <= 2'b00;
          d_in_valid <= 1'b1;
          flush_cnt  <= flush_cnt + 11'd1;
          if (flush_cnt == FLUSH_LAST) state <= DRAIN;
        end

        DRAIN: begin
          d_in_valid <= 1'b0;
          if (d_out_valid) begin
            wd_cnt <= '0;
          end else if (wd_cnt == WD_LAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 11'd1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase

      // Decoded bits are forwarded in every active state; the last one overrides the state sequence.
      if ((state inside {FEED, FLUSH, DRAIN}) && d_out_valid && (bit_cnt < OUT_TOTAL)) begin
        m_valid <= 1'b1;
        m_data  <= d_out;
        bit_cnt <= bit_cnt + 11'd1;
        if (bit_cnt == OUT_LAST) begin
          m_last      <= 1'b1;
          done        <= 1'b1;
          err_timeout <= 1'b0;
          busy        <= 1'b1;
          state       <= DONE;
          s_ready     <= 1'b0;
          if (state == FLUSH) d_in_valid <= 1'b0;
        end
      end
    end
  end

endmodule
